// File: rtl/rej_bounded_poly_stream.sv
// Streaming rejection sampler for bounded polynomial coefficients.
// It turns SHAKE256 squeeze words into signed coefficients in [-ETA, ETA],
// and it can produce several polynomials back to back.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | in_ready high, waiting for the next squeeze word
// S_SCAN  | one nibble per cycle, lowest first; stalls while output is full
// S_DRAIN | Nth coefficient is registered, waiting for its handshake
// S_FIN   | done pulse, then back to idle
module rej_bounded_poly_stream #(
  parameter int N            = 256,
  parameter int DATA_IN_BITS = 64,
  parameter int COEFF_WIDTH  = 4,
  parameter int POLY_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    eta_sel,
  input  logic [POLY_W-1:0]       num_poly,
  input  logic [DATA_IN_BITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [COEFF_WIDTH-1:0]  coeff_out,
  output logic [$clog2(N)-1:0]    coeff_idx,
  output logic [POLY_W-1:0]       poly_idx,
  output logic                    coeff_valid,
  input  logic                    coeff_ready,
  output logic                    poly_done,
  output logic                    squeeze_stop,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(N);
  localparam int NIBS  = DATA_IN_BITS / 4;
  localparam int PTR_W = $clog2(NIBS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic                    eta4_q;
  logic [POLY_W-1:0]       num_poly_q;
  logic [DATA_IN_BITS-1:0] word_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        next_idx_q;

  logic [3:0]              nib;
  logic [3:0]              mod5;
  logic                    accept;
  logic [COEFF_WIDTH-1:0]  nib_coeff;
  logic                    out_free;
  logic                    scan_step;
  logic                    take;
  logic                    last_coeff;
  logic                    last_nib;
  logic                    last_poly;
  logic                    drain_hs;

  // The word is shifted right after each nibble, so the current nibble is always bits [3:0]
  assign out_free   = !coeff_valid || coeff_ready;
  assign scan_step  = (state_q == S_SCAN) && out_free;
  assign take       = scan_step && accept;
  assign last_coeff = take && (next_idx_q == IDX_W'(N - 1));
  assign last_nib   = (ptr_q == PTR_W'(NIBS - 1));
  assign last_poly  = (poly_idx == num_poly_q - POLY_W'(1));
  assign drain_hs   = (state_q == S_DRAIN) && coeff_valid && coeff_ready;

  // Nibble acceptance test and coefficient mapping for the latched ETA
  always_comb begin
    nib = word_q[3:0];
    if (nib >= 4'd10) begin
      mod5 = nib - 4'd10;
    end else if (nib >= 4'd5) begin
      mod5 = nib - 4'd5;
    end else begin
      mod5 = nib;
    end
    if (eta4_q) begin
      accept    = (nib < 4'd9);
      nib_coeff = COEFF_WIDTH'(4 - int'(nib));
    end else begin
      accept    = (nib < 4'd15);
      nib_coeff = COEFF_WIDTH'(2 - int'(mod5));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    poly_done    = 1'b0;
    squeeze_stop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_poly == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_coeff) begin
          state_d = S_DRAIN;
        end else if (scan_step && last_nib) begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_hs) begin
          poly_done    = 1'b1;
          squeeze_stop = 1'b1;
          state_d      = last_poly ? S_FIN : S_LOAD;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job parameters, word buffer, nibble pointer and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta4_q      <= 1'b0;
      num_poly_q  <= '0;
      word_q      <= '0;
      ptr_q       <= '0;
      next_idx_q  <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      poly_idx    <= '0;
      coeff_valid <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        eta4_q     <= eta_sel;
        num_poly_q <= num_poly;
        coeff_idx  <= '0;
        poly_idx   <= '0;
        next_idx_q <= '0;
      end
      if (in_ready && in_valid) begin
        word_q <= in_data;
        ptr_q  <= '0;
      end else if (scan_step) begin
        word_q <= word_q >> 4;
        ptr_q  <= ptr_q + PTR_W'(1);
      end
      if (coeff_valid && coeff_ready) begin
        coeff_valid <= 1'b0;
      end
      if (take) begin
        coeff_valid <= 1'b1;
        coeff_out   <= nib_coeff;
        coeff_idx   <= next_idx_q;
        next_idx_q  <= next_idx_q + IDX_W'(1);
      end
      if (drain_hs && !last_poly) begin
        poly_idx   <= poly_idx + POLY_W'(1);
        coeff_idx  <= '0;
        next_idx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rej_bounded_poly_stream.sv
// Testbench for rej_bounded_poly_stream: random and directed jobs compared
// against a word-level reference model of the rejection sampling rule.
module tb_rej_bounded_poly_stream;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        eta_sel = 1'b0;
  logic [3:0]  num_poly = '0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  coeff_out;
  logic [7:0]  coeff_idx;
  logic [3:0]  poly_idx;
  logic        coeff_valid;
  logic        coeff_ready = 1'b0;
  logic        poly_done;
  logic        squeeze_stop;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] words[$];
  int          exp_c[$];
  int          exp_i[$];
  int          exp_p[$];
  int          exp_words;
  bit          first_nib_ok;

  rej_bounded_poly_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .eta_sel      (eta_sel),
    .num_poly     (num_poly),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .coeff_out    (coeff_out),
    .coeff_idx    (coeff_idx),
    .poly_idx     (poly_idx),
    .coeff_valid  (coeff_valid),
    .coeff_ready  (coeff_ready),
    .poly_done    (poly_done),
    .squeeze_stop (squeeze_stop),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void fill_words(input int mode);
    words.delete();
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0:       words.push_back({$urandom, $urandom});
        1:       words.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        2:       words.push_back(64'h0);
        default: words.push_back(64'hFEDC_BA98_7654_3210);
      endcase
    end
  endfunction

  function automatic bit nib_ok(input bit eta4, input int z);
    return eta4 ? (z < 9) : (z < 15);
  endfunction

  // Reference: walk the word list, nibbles low first, N accepted per polynomial,
  // the rest of the word holding the Nth acceptance is thrown away.
  function automatic void build_model(input bit eta4, input int npoly);
    int wi = 0;
    exp_c.delete();
    exp_i.delete();
    exp_p.delete();
    for (int p = 0; p < npoly; p++) begin
      int cnt = 0;
      while (cnt < N && wi < words.size()) begin
        logic [63:0] w = words[wi];
        wi++;
        for (int k = 0; k < 16; k++) begin
          int z = int'((w >> (4 * k)) & 64'hF);
          if (cnt < N && nib_ok(eta4, z)) begin
            exp_c.push_back(eta4 ? 4 - z : 2 - (z % 5));
            exp_i.push_back(cnt);
            exp_p.push_back(p);
            cnt++;
          end
        end
      end
    end
    exp_words    = wi;
    first_nib_ok = (npoly > 0) && nib_ok(eta4, int'(words[0] & 64'hF));
  endfunction

  task automatic do_reset();
    start       = 1'b0;
    in_valid    = 1'b0;
    coeff_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", longint'({in_ready, coeff_valid, coeff_out, coeff_idx, poly_idx,
                                 poly_done, squeeze_stop, busy, done}), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs_hold", longint'({in_ready, coeff_valid, coeff_out, coeff_idx, poly_idx,
                                      poly_done, squeeze_stop, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 toggling 1010..., 2 random
  task automatic run_job(input bit eta4, input int npoly, input int ready_mode,
                         input int valid_pct, input bit poke, input int abort_at);
    int   got = 0;
    int   wi = 0;
    int   pd_cnt = 0;
    int   last_pd = -1;
    int   done_cyc = -1;
    int   hs0 = -1;
    int   hs1 = -1;
    int   first_v = -1;
    bit   prev_stall = 1'b0;
    bit   in_hs;
    bit   out_hs;
    logic [3:0] pc = '0;
    logic [7:0] pi = '0;
    logic [3:0] pp = '0;
    int   limit = (abort_at > 0) ? abort_at : 20000;
    build_model(eta4, npoly);
    for (int cyc = 0; cyc < limit; cyc++) begin
      start = (cyc == 0) || (poke && cyc == 300);
      if (cyc == 0) begin
        eta_sel  = eta4;
        num_poly = 4'(npoly);
      end else begin
        eta_sel  = 1'($urandom);
        num_poly = 4'($urandom);
      end
      in_valid = (int'($urandom_range(99)) < valid_pct) && (wi < words.size());
      in_data  = in_valid ? words[wi] : {$urandom, $urandom};
      case (ready_mode)
        0:       coeff_ready = 1'b1;
        1:       coeff_ready = (cyc % 2 == 0);
        default: coeff_ready = 1'($urandom);
      endcase
      #1;
      if (cyc == 1) chk("busy_after_start", longint'(busy), longint'(npoly != 0));
      if (prev_stall)
        chk("hold_while_stalled", longint'({coeff_valid, coeff_out, coeff_idx, poly_idx}),
            longint'({1'b1, pc, pi, pp}));
      in_hs  = in_valid && in_ready;
      out_hs = coeff_valid && coeff_ready;
      if (coeff_valid && first_v < 0) first_v = cyc;
      if (in_hs) begin
        if (hs0 < 0) hs0 = cyc;
        else if (hs1 < 0) hs1 = cyc;
        wi++;
      end
      if (out_hs) begin
        if (got < exp_c.size()) begin
          chk("coeff", longint'($signed(coeff_out)), longint'(exp_c[got]));
          chk("coeff_idx", longint'(coeff_idx), longint'(exp_i[got]));
          chk("poly_idx", longint'(poly_idx), longint'(exp_p[got]));
        end else begin
          chk("extra_coeff", longint'(got), longint'(exp_c.size()));
        end
        got++;
      end
      if (poly_done || squeeze_stop)
        chk("squeeze_with_poly_done", longint'(squeeze_stop), longint'(poly_done));
      if (poly_done) begin
        chk("poly_done_on_last", longint'({out_hs, coeff_idx}), longint'({1'b1, 8'd255}));
        pd_cnt++;
        last_pd = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", longint'(busy), 0);
      end
      prev_stall = coeff_valid && !coeff_ready;
      pc = coeff_out;
      pi = coeff_idx;
      pp = poly_idx;
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (abort_at > 0) return;
    chk("done_seen", longint'(done_cyc >= 0), 1);
    chk("num_coeffs", longint'(got), longint'(exp_c.size()));
    chk("words_consumed", longint'(wi), longint'(exp_words));
    chk("poly_done_count", longint'(pd_cnt), longint'(npoly));
    if (npoly > 0) chk("done_after_poly_done", longint'(done_cyc - last_pd), 1);
    else           chk("done_latency_empty", longint'(done_cyc), 1);
    if (first_nib_ok) chk("first_coeff_latency", longint'(first_v - hs0), 2);
    if (npoly > 0 && valid_pct == 100 && ready_mode == 0)
      chk("word_period", longint'(hs1 - hs0), 17);
  endtask

  // All-rejecting words: the sampler must keep asking for words and never emit
  task automatic run_stuck();
    int hs_prev = -1;
    int nvalid  = 0;
    int npd     = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      start       = (cyc == 0);
      eta_sel     = 1'b0;
      num_poly    = 4'd1;
      in_valid    = 1'b1;
      in_data     = 64'hFFFF_FFFF_FFFF_FFFF;
      coeff_ready = 1'b1;
      #1;
      if (in_ready) begin
        if (hs_prev >= 0) chk("reject_word_period", longint'(cyc - hs_prev), 17);
        hs_prev = cyc;
      end
      nvalid += int'(coeff_valid);
      npd    += int'(poly_done);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("reject_no_coeff", longint'(nvalid), 0);
    chk("reject_no_poly_done", longint'(npd), 0);
    chk("reject_still_busy", longint'(busy), 1);
  endtask

  initial begin
    do_reset();
    fill_words(3);
    run_job(1'b1, 1, 0, 100, 1'b0, 0);
    run_job(1'b0, 1, 0, 100, 1'b0, 0);
    run_job(1'b1, 1, 1, 100, 1'b0, 0);
    fill_words(2);
    run_job(1'b0, 2, 0, 100, 1'b0, 0);
    run_stuck();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      fill_words(0);
      run_job(1'($urandom), 1 + int'($urandom_range(1)), int'($urandom_range(2)),
              60 + int'($urandom_range(40)), (r == 1), 0);
    end
    fill_words(2);
    run_job(1'b0, 2, 0, 100, 1'b0, 300);
    do_reset();
    fill_words(0);
    run_job(1'b1, 1, 2, 80, 1'b0, 0);
    run_job(1'b1, 0, 0, 100, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
